floppy_track_buf: RTL and testbench
===================================

// Module: floppy_track_buf
// PURPOSE
//  Track cache for one 5.25" drive: holds one 6656-byte nibble track (13 x 512-byte SD blocks)
//  in an 8 KB RAM. The IWM reads/writes the RAM through a CPU-side port. On a track change,
//  a dirty track is written back to SD, then the new track is loaded. Sits between iigs TRACKn_* and the SD block interface.
// PARAMETERS
//  BLKS_PER_TRACK  13  SD blocks per track; LBA = track*BLKS_PER_TRACK + blk
// PORTS
//  clk           in   1   system clock, all logic posedge
//  reset         in   1   asynchronous, active-low reset
//  ram_addr      in   13  CPU-side byte address (0..6655 meaningful, up to 8191 stored)
//  ram_di        in   8   CPU-side write data
//  ram_do        out  8   CPU-side read data, registered, 1-cycle latency
//  ram_we        in   1   CPU-side write strobe
//  track         in   6   requested track number
//  busy          out  1   transfer in progress; CPU-side contents invalid
//  change        in   1   toggles on every disk insertion
//  mount         in   1   level: disk image present
//  ready         out  1   disk present and current track loaded
//  active        out  1   activity LED: high while sd_rd, sd_wr or sd_ack is high
//  sd_buff_addr  in   9   byte offset within current SD block
//  sd_buff_dout  in   8   SD->buffer data
//  sd_buff_din   out  8   buffer->SD data, registered, 1-cycle latency from sd_buff_addr
//  sd_buff_wr    in   1   SD data strobe (valid only while sd_ack=1)
//  sd_lba        out  32  block address of current request
//  sd_rd         out  1   block read request
//  sd_wr         out  1   block write request
//  sd_ack        in   1   host acknowledge; high for the duration of one block transfer
// BEHAVIOUR
//  Reset: state IDLE, busy=0, ready=0, active=0, sd_rd=sd_wr=0, sd_lba=0, ram_do=0,
//   sd_buff_din=0, dirty=0, cur_valid=0, blk=0. RAM contents not cleared. Reset mid-transfer aborts the transfer silently.
//  RAM: 8192x8 true dual port. Port A = CPU (ram_*). Port B = SD, address {blk[3:0],sd_buff_addr} = blk*512+off.
//   A CPU write with busy=0 stores ram_di and sets dirty. A CPU write with busy=1 is ignored.
//   An SD write (sd_buff_wr & sd_ack, READ state) stores sd_buff_dout.
//  change: a toggle (XOR against the registered previous value) sets reload_pend.
//  States: IDLE, REQ, XFER, NEXT.
//   IDLE: if !mount -> ready=0, cur_valid=0, no SD activity.
//     else if reload_pend: clear reload_pend and dirty, cur_valid=0, dir=READ, start.
//     else if !cur_valid or track!=cur_track: if dirty & cur_valid -> dir=WRITE of cur_track,
//     else dir=READ of track (latch tgt=track). Start = blk<=0, busy<=1, ready<=0, go to REQ.
//   REQ: sd_lba=tgt*13+blk; assert sd_rd (READ) or sd_wr (WRITE); on sd_ack rising drop request -> XFER.
//   XFER: wait for sd_ack falling -> NEXT.
//   NEXT: if blk<12: blk++ -> REQ. Else if WRITE: dirty=0, dir=READ, tgt=track, blk=0 -> REQ.
//     Else READ done: cur_track=tgt, cur_valid=1, busy=0, ready=1 -> IDLE.
//  A track change during a transfer is not acted on mid-sequence; IDLE re-evaluates after completion, so the newest track wins.
//  A change toggle mid-transfer is latched and processed in the next IDLE; any dirty data is discarded.
//  mount falling mid-transfer: current block finishes (ack handshake); then IDLE drops ready.
//  sd_buff_wr outside READ/XFER is ignored. busy/ready/sd_* are registered outputs.
// TESTING
//  1 Reset low, then mount=1, track=0: sd_rd rises, sd_lba=0..12 over 13 acks; then busy=0, ready=1.
//  2 Load track 3; CPU reads addr 512 -> next-cycle ram_do equals SD byte 0 of LBA 40.
//  3 CPU writes 0xA5 @0x0005 on track 3, then track=4: sd_wr for LBA 39..51 with byte 5 of LBA 39 = 0xA5; then sd_rd LBA 52..64.
//  4 Clean track 3 -> track 4: no sd_wr, only sd_rd LBA 52..64.
//  5 Toggle change while dirty: no write-back; track re-read from LBA track*13; dirty=0.
//  6 Reset low mid-block (sd_ack=1): sd_rd=0, busy=0, ready=0 immediately; next load restarts at blk 0.

Source files
------------

// File: rtl/floppy_track_buf.sv
// Track cache for one 5.25" drive.
// Holds one 6656-byte nibble track (13 x 512-byte SD blocks) in an 8 KB dual-port RAM.
// The CPU side (IWM) reads and writes the RAM directly. When the requested track changes,
// a dirty track is first written back to SD, and then the new track is read in.
//
// Ports:
//   i_clk, i_rst_n       clock; asynchronous active-low reset
//   i_ram_addr/di/we     CPU-side byte port. o_ram_do is registered (1-cycle latency).
//   i_track              requested track number
//   i_change             toggles on every disk insertion; a toggle forces a reload
//   i_mount              disk image present (level)
//   o_busy               transfer in progress; CPU-side contents are not valid
//   o_ready              disk present and the current track is loaded
//   o_active             activity LED
//   i_sd_buff_*          SD buffer port. o_sd_buff_din is registered (1-cycle latency).
//   o_sd_lba/rd/wr       SD block request
//   i_sd_ack             host acknowledge, high for one whole block transfer
module floppy_track_buf #(
    parameter int unsigned BLKS_PER_TRACK = 13
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [12:0] i_ram_addr,
    input  logic [7:0]  i_ram_di,
    output logic [7:0]  o_ram_do,
    input  logic        i_ram_we,
    input  logic [5:0]  i_track,
    output logic        o_busy,
    input  logic        i_change,
    input  logic        i_mount,
    output logic        o_ready,
    output logic        o_active,
    input  logic [8:0]  i_sd_buff_addr,
    input  logic [7:0]  i_sd_buff_dout,
    output logic [7:0]  o_sd_buff_din,
    input  logic        i_sd_buff_wr,
    output logic [31:0] o_sd_lba,
    output logic        o_sd_rd,
    output logic        o_sd_wr,
    input  logic        i_sd_ack
);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StNext} state_t;
    typedef enum logic {DirRead, DirWrite} dir_t;

    localparam logic [3:0] LastBlk = 4'(BLKS_PER_TRACK - 1);

    state_t      r_state;
    dir_t        r_dir;
    logic [3:0]  r_blk;
    logic [5:0]  r_tgt;
    logic [5:0]  r_cur_track;
    logic        r_cur_valid;
    logic        r_dirty;
    logic        r_reload_pend;
    logic        r_change_q;
    logic        r_ack_q;
    logic        r_busy;
    logic        r_ready;
    logic        r_active;
    logic        r_sd_rd;
    logic        r_sd_wr;
    logic [31:0] r_sd_lba;
    logic [7:0]  r_ram_do;
    logic [7:0]  r_sd_din;

    logic [7:0]  r_mem [8192];

    logic        w_cpu_we;
    logic        w_sd_we;
    logic [12:0] w_sd_addr;
    logic [31:0] w_lba;
    logic        w_ack_rise;

    assign w_cpu_we   = i_ram_we & ~r_busy;
    // SD data only lands in RAM while a read block is being transferred.
    assign w_sd_we    = i_sd_buff_wr & i_sd_ack & (r_dir == DirRead) &
                        ((r_state == StReq) || (r_state == StXfer));
    assign w_sd_addr  = {r_blk, i_sd_buff_addr};
    assign w_lba      = {26'd0, r_tgt} * 32'(BLKS_PER_TRACK) + {28'd0, r_blk};
    assign w_ack_rise = i_sd_ack & ~r_ack_q;

    // RAM array: no reset. CPU writes are only possible while idle and SD writes only
    // while busy, so the two ports never collide.
    always_ff @(posedge i_clk) begin
        if (w_cpu_we) begin
            r_mem[i_ram_addr] <= i_ram_di;
        end else if (w_sd_we) begin
            r_mem[w_sd_addr] <= i_sd_buff_dout;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ram_do <= 8'd0;
            r_sd_din <= 8'd0;
        end else begin
            r_ram_do <= r_mem[i_ram_addr];
            r_sd_din <= r_mem[w_sd_addr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_dir         <= DirRead;
            r_blk         <= 4'd0;
            r_tgt         <= 6'd0;
            r_cur_track   <= 6'd0;
            r_cur_valid   <= 1'b0;
            r_dirty       <= 1'b0;
            r_reload_pend <= 1'b0;
            r_change_q    <= 1'b0;
            r_ack_q       <= 1'b0;
            r_busy        <= 1'b0;
            r_ready       <= 1'b0;
            r_active      <= 1'b0;
            r_sd_rd       <= 1'b0;
            r_sd_wr       <= 1'b0;
            r_sd_lba      <= 32'd0;
        end else begin
            r_change_q <= i_change;
            r_ack_q    <= i_sd_ack;
            r_active   <= r_sd_rd | r_sd_wr | i_sd_ack;

            // FSM clears below take priority over a same-cycle CPU write.
            if (w_cpu_we) begin
                r_dirty <= 1'b1;
            end

            unique case (r_state)
                StIdle: begin
                    if (!i_mount) begin
                        r_ready     <= 1'b0;
                        r_cur_valid <= 1'b0;
                    end else if (r_reload_pend) begin
                        // New disk: whatever is cached is stale, drop it unwritten.
                        r_reload_pend <= 1'b0;
                        r_dirty       <= 1'b0;
                        r_cur_valid   <= 1'b0;
                        r_dir         <= DirRead;
                        r_tgt         <= i_track;
                        r_blk         <= 4'd0;
                        r_busy        <= 1'b1;
                        r_ready       <= 1'b0;
                        r_state       <= StReq;
                    end else if (!r_cur_valid || (i_track != r_cur_track)) begin
                        if (r_dirty && r_cur_valid) begin
                            r_dir <= DirWrite;
                            r_tgt <= r_cur_track;
                        end else begin
                            r_dir <= DirRead;
                            r_tgt <= i_track;
                        end
                        r_blk   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= StReq;
                    end
                end
                StReq: begin
                    if (w_ack_rise) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_state <= StXfer;
                    end else begin
                        r_sd_lba <= w_lba;
                        r_sd_rd  <= (r_dir == DirRead);
                        r_sd_wr  <= (r_dir == DirWrite);
                    end
                end
                StXfer: begin
                    if (!i_sd_ack) begin
                        r_state <= StNext;
                    end
                end
                StNext: begin
                    if (!i_mount) begin
                        // Disk gone: stop after the block that just finished.
                        r_busy      <= 1'b0;
                        r_ready     <= 1'b0;
                        r_cur_valid <= 1'b0;
                        r_state     <= StIdle;
                    end else if (r_blk != LastBlk) begin
                        r_blk   <= r_blk + 4'd1;
                        r_state <= StReq;
                    end else if (r_dir == DirWrite) begin
                        // Write-back done; chain straight into reading the newest track.
                        r_dirty <= 1'b0;
                        r_dir   <= DirRead;
                        r_tgt   <= i_track;
                        r_blk   <= 4'd0;
                        r_state <= StReq;
                    end else begin
                        r_cur_track <= r_tgt;
                        r_cur_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Placed after the FSM so a toggle coinciding with a reload is not lost.
            if (i_change ^ r_change_q) begin
                r_reload_pend <= 1'b1;
            end
        end
    end

    assign o_ram_do      = r_ram_do;
    assign o_sd_buff_din = r_sd_din;
    assign o_busy        = r_busy;
    assign o_ready       = r_ready;
    assign o_active      = r_active;
    assign o_sd_rd       = r_sd_rd;
    assign o_sd_wr       = r_sd_wr;
    assign o_sd_lba      = r_sd_lba;

endmodule

// File: tb/tb_floppy_track_buf.sv
// Self-checking bench for floppy_track_buf: an SD host model backed by a sparse disk image,
// and a track-level reference model of the cache contents and expected request sequences.
module tb_floppy_track_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] ram_addr = '0;
    logic [7:0]  ram_di = '0;
    logic [7:0]  ram_do;
    logic        ram_we = 1'b0;
    logic [5:0]  track = '0;
    logic        busy;
    logic        change = 1'b0;
    logic        mount = 1'b0;
    logic        ready;
    logic        active;
    logic [8:0]  sd_buff_addr = '0;
    logic [7:0]  sd_buff_dout = '0;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    int unsigned seed;
    logic [7:0]  disk [int];
    logic [7:0]  model_ram [8192];
    bit          model_dirty = 0;
    bit          model_valid = 0;
    int          model_track = 0;
    int          log_lba [$];
    bit          log_wr [$];

    floppy_track_buf #(.BLKS_PER_TRACK(13)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_ram_addr     (ram_addr),
        .i_ram_di       (ram_di),
        .o_ram_do       (ram_do),
        .i_ram_we       (ram_we),
        .i_track        (track),
        .o_busy         (busy),
        .i_change       (change),
        .i_mount        (mount),
        .o_ready        (ready),
        .o_active       (active),
        .i_sd_buff_addr (sd_buff_addr),
        .i_sd_buff_dout (sd_buff_dout),
        .o_sd_buff_din  (sd_buff_din),
        .i_sd_buff_wr   (sd_buff_wr),
        .o_sd_lba       (sd_lba),
        .o_sd_rd        (sd_rd),
        .o_sd_wr        (sd_wr),
        .i_sd_ack       (sd_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] disk_byte(int lba, int off);
        if (disk.exists(lba * 512 + off)) return disk[lba * 512 + off];
        return 8'((lba * 37) ^ (off * 11) ^ (off >> 4) ^ int'(seed));
    endfunction

    // Cache now holds the given track exactly as the disk has it.
    function automatic void model_load(int t);
        for (int b = 0; b < 13; b++)
            for (int o = 0; o < 512; o++)
                model_ram[b * 512 + o] = disk_byte(t * 13 + b, o);
        model_track = t;
        model_valid = 1;
        model_dirty = 0;
    endfunction

    task automatic cpu_write(input int a, input logic [7:0] d);
        ram_addr = 13'(a);
        ram_di   = d;
        ram_we   = 1'b1;
        tick();
        ram_we   = 1'b0;
    endtask

    task automatic cpu_read(input int a, output logic [7:0] d);
        ram_addr = 13'(a);
        tick();
        d = ram_do;
    endtask

    // SD host: serve one block request currently on sd_rd/sd_wr.
    task automatic serve_block();
        int lba;
        bit w;
        lba = int'(sd_lba);
        w   = sd_wr;
        log_lba.push_back(lba);
        log_wr.push_back(w);
        sd_ack = 1'b1;
        tick();
        if (!w) begin
            for (int k = 0; k < 512; k++) begin
                sd_buff_addr = 9'(k);
                sd_buff_dout = disk_byte(lba, k);
                sd_buff_wr   = 1'b1;
                tick();
            end
            sd_buff_wr = 1'b0;
        end else begin
            for (int k = 0; k < 512; k++) begin
                sd_buff_addr = 9'(k);
                tick();
                disk[lba * 512 + k] = sd_buff_din;
            end
        end
        sd_ack = 1'b0;
        tick();
    endtask

    // Wait for busy, then serve blocks until busy drops. ok=0 if any bound expires.
    task automatic run_transfer(output bit ok);
        int n;
        int blocks;
        ok = 0;
        blocks = 0;
        log_lba.delete();
        log_wr.delete();
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        if (!busy) return;
        forever begin
            n = 0;
            while (!(sd_rd || sd_wr) && busy && n < 200) begin tick(); n++; end
            if (!busy) begin ok = 1; return; end
            if (n >= 200) return;
            serve_block();
            blocks++;
            if (blocks > 40) return;
        end
    endtask

    // Compare the logged requests with: optional write-back of wr_t, then read of rd_t.
    task automatic check_seq(input string name, input int wr_t, input int rd_t, input bit ok);
        int exp_lba [$];
        bit exp_wr [$];
        int bad_at;
        if (wr_t >= 0)
            for (int b = 0; b < 13; b++) begin exp_lba.push_back(wr_t * 13 + b); exp_wr.push_back(1); end
        for (int b = 0; b < 13; b++) begin exp_lba.push_back(rd_t * 13 + b); exp_wr.push_back(0); end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: transfer timed out after %0d requests, expected %0d",
                     name, log_lba.size(), exp_lba.size());
            return;
        end
        if (log_lba.size() !== exp_lba.size()) begin
            errors++;
            $display("FAIL %s: got %0d requests, expected %0d", name, log_lba.size(), exp_lba.size());
            return;
        end
        bad_at = -1;
        for (int i = 0; i < exp_lba.size(); i++)
            if (bad_at < 0 && (log_lba[i] !== exp_lba[i] || log_wr[i] !== exp_wr[i])) bad_at = i;
        if (bad_at >= 0) begin
            errors++;
            $display("FAIL %s: request %0d got lba %0d wr %0d, expected lba %0d wr %0d", name,
                     bad_at, log_lba[bad_at], log_wr[bad_at], exp_lba[bad_at], exp_wr[bad_at]);
        end
    endtask

    task automatic check_ram(input string name, input int n);
        logic [7:0] d;
        int a;
        for (int i = 0; i < n; i++) begin
            a = int'($urandom_range(0, 6655));
            cpu_read(a, d);
            checks++;
            if (d !== model_ram[a]) begin
                errors++;
                $display("FAIL %s: ram[%0d] got %02h expected %02h", name, a, d, model_ram[a]);
            end
        end
    endtask

    task automatic check_flags(input string name, input logic b, input logic r);
        checks++;
        if (busy !== b || ready !== r) begin
            errors++;
            $display("FAIL %s: busy/ready got %b/%b expected %b/%b", name, busy, ready, b, r);
        end
    endtask

    // Change to track t; expected write-back derived from the model's dirty state.
    task automatic goto_track(input string name, input int t);
        bit ok;
        int wr_t;
        wr_t = (model_valid && model_dirty && t != model_track) ? model_track : -1;
        track = 6'(t);
        run_transfer(ok);
        check_seq(name, wr_t, t, ok);
        if (wr_t >= 0) begin
            int bad;
            bad = -1;
            for (int i = 0; i < 6656; i++) begin
                int idx;
                idx = (wr_t * 13 + i / 512) * 512 + i % 512;
                if (bad < 0 && (!disk.exists(idx) || disk[idx] !== model_ram[i])) bad = i;
            end
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s_wbdata: byte %0d got %02h expected %02h", name, bad,
                         disk_byte(wr_t * 13 + bad / 512, bad % 512), model_ram[bad]);
            end
        end
        model_load(t);
        check_flags(name, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, ready, active, sd_rd, sd_wr} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, ready, active, sd_rd, sd_wr});
        end
        checks++;
        if (sd_lba !== 32'd0 || ram_do !== 8'd0 || sd_buff_din !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: lba %0d ram_do %02h din %02h expected 0", sd_lba, ram_do,
                     sd_buff_din);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (busy !== 1'b0 || sd_rd !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL unmounted_idle: busy %b rd %b ready %b expected 0", busy, sd_rd, ready);
        end
    endtask

    task automatic test_initial_load();
        mount = 1'b1;
        goto_track("load_t0", 0);
        check_ram("ram_t0", 8);
    endtask

    task automatic test_track3_read();
        logic [7:0] d;
        goto_track("load_t3", 3);
        cpu_read(512, d);
        checks++;
        if (d !== disk_byte(40, 0)) begin
            errors++;
            $display("FAIL read512: got %02h expected %02h", d, disk_byte(40, 0));
        end
        check_ram("ram_t3", 8);
    endtask

    task automatic test_dirty_writeback();
        for (int i = 0; i < 16; i++) begin
            int a;
            logic [7:0] v;
            a = int'($urandom_range(0, 6655));
            v = 8'($urandom);
            cpu_write(a, v);
            model_ram[a] = v;
        end
        cpu_write(5, 8'hA5);
        model_ram[5] = 8'hA5;
        model_dirty = 1;
        goto_track("wb_t3_t4", 4);
        checks++;
        if (disk_byte(39, 5) !== 8'hA5) begin
            errors++;
            $display("FAIL wb_byte5: got %02h expected a5", disk_byte(39, 5));
        end
        check_ram("ram_t4", 8);
    endtask

    task automatic test_clean_change();
        goto_track("clean_t4_t3", 3);
        goto_track("clean_t3_t4", 4);
    endtask

    task automatic test_change_toggle();
        bit ok;
        int n;
        logic [7:0] v;
        logic [7:0] d;
        v = 8'($urandom);
        cpu_write(7000, v);
        model_ram[7000] = v;
        cpu_write(100, ~disk_byte(52, 100));
        model_dirty = 1;
        change = ~change;
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        // Writes while busy must be dropped and must not mark the track dirty.
        cpu_write(7000, ~v);
        cpu_write(6000, 8'h3C);
        run_transfer(ok);
        check_seq("reload_t4", -1, 4, ok);
        model_load(4);
        cpu_read(7000, d);
        checks++;
        if (d !== v) begin
            errors++;
            $display("FAIL busy_write: ram[7000] got %02h expected %02h", d, v);
        end
        check_ram("ram_reload", 8);
        goto_track("after_reload_t5", 5);
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        track = 6'd6;
        n = 0;
        while (!sd_rd && n < 40) begin tick(); n++; end
        checks++;
        if (sd_rd !== 1'b1) begin
            errors++;
            $display("FAIL mid_req: sd_rd got %b expected 1", sd_rd);
        end
        tick();
        checks++;
        if (active !== 1'b1 || sd_lba !== 32'd78) begin
            errors++;
            $display("FAIL mid_active: active %b lba %0d expected 1 / 78", active, sd_lba);
        end
        sd_ack = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            sd_buff_addr = 9'(k);
            sd_buff_dout = 8'($urandom);
            sd_buff_wr   = 1'b1;
            tick();
        end
        sd_buff_wr = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sd_rd !== 1'b0 || busy !== 1'b0 || ready !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rd %b busy %b ready %b active %b expected 0", sd_rd, busy,
                     ready, active);
        end
        sd_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        model_valid = 0;
        model_dirty = 0;
        run_transfer(ok);
        check_seq("restart_t6", -1, 6, ok);
        model_load(6);
        check_flags("restart_t6", 1'b0, 1'b1);
        check_ram("ram_t6", 6);
    endtask

    initial begin
        seed = $urandom;
        test_reset();
        test_initial_load();
        test_track3_read();
        test_dirty_writeback();
        test_clean_change();
        test_change_toggle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
